exe: RTL and testbench
======================

# exe

Execute stage of the multi-cycle CPU. It sits between the decode stage and the `mem` access stage. It consumes the ID→EXE bus and produces the 106-bit EXE→MEM bus. It evaluates ALU operations in one cycle, owns the HI/LO registers, and runs signed 32×32 `MULT` on an iterative 32-step multiplier. `EXE_over` tells the stage controller when the result is ready.

## Interface
- No parameters; all widths are fixed by the bus formats.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `EXE_valid`  in  1  EXE stage holds a valid instruction.
- `ID_EXE_bus_r`  in  155  concatenation, MSB first:
  - `multiply`, `mthi`, `mtlo`, `mfhi`, `mflo` (1 each)
  - `alu_control[11:0]`
  - `alu_operand1[31:0]`, `alu_operand2[31:0]`
  - `mem_control[3:0]`, `store_data[31:0]`
  - `rf_wen`, `rf_wdest[4:0]`
  - `pc[31:0]`
- `EXE_over`  out  1  EXE work for the current instruction is complete.
- `EXE_MEM_bus`  out  106  `{mem_control[3:0], store_data[31:0], exe_result[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}`.
- `EXE_pc`  out  32  PC of the instruction in EXE, for display.

## Operation
- **ALU path.** The one-hot `alu_control` bits are add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui. They drive the shared combinational ALU on `alu_operand1` and `alu_operand2`.
- **`exe_result` selection.**
  - `mfhi` selects HI.
  - `mflo` selects LO.
  - Otherwise the ALU result.
  - `multiply` instructions set `rf_wen=0` upstream; EXE forwards `rf_wen` unchanged.
- **Pass-through.** `mem_control`, `store_data`, `rf_wen`, `rf_wdest` and `pc` go to `EXE_MEM_bus` unchanged. `EXE_pc` equals `pc`.
- **`EXE_over`.**
  - Multiply instruction: equals `mult_end`.
  - Any other instruction: equals `EXE_valid`.
- **HI/LO writes.** HI and LO are 32-bit registers, both reset to 0.
  - `mthi`: HI ← `alu_operand1` on the edge ending a cycle where `EXE_valid & mthi`.
  - `mtlo`: LO ← `alu_operand1`, same condition with `mtlo`.
  - Multiply: `{HI,LO}` ← product on the edge ending the DONE cycle.
- **Multiplier FSM (in `multiply` sub-module).** States IDLE, RUN, DONE.
  - IDLE→RUN when `mult_begin = EXE_valid & multiply` while in IDLE. On entry, latch `|op1|` and `|op2|` as 32-bit unsigned values, record `sign = op1[31]^op2[31]`, clear the 64-bit accumulator, and set the 6-bit counter to 0.
  - RUN, each cycle: if the current LSB of the multiplier is 1, add the shifted multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; increment the counter.
  - RUN→DONE after the 32nd step (counter reaches 32).
  - DONE: `mult_end=1` for exactly one cycle. Product = `sign ? -acc : acc`, in 64-bit two's complement. DONE→IDLE unconditionally.
  - If `EXE_valid & multiply` is still high in the cycle after DONE, a new multiply starts. The stage controller deasserts `EXE_valid` after sampling `EXE_over`.
- **Arithmetic edge case.** `|0x80000000|` is `0x80000000` as a 32-bit unsigned value; no overflow handling is needed.
- **Reset.** `reset` forces IDLE, counter 0, accumulator 0, HI=0, LO=0. Reset overrides any in-flight multiply, and any write scheduled for that edge is dropped.
- **Invalid stage.** `EXE_valid=0` blocks all HI/LO writes and multiplier starts. A multiply already in RUN continues to DONE, but its HI/LO write is dropped if `EXE_valid=0` during DONE.

## Timing
- **ALU, MF, MT instructions:** `EXE_over` is high in the same cycle as `EXE_valid` (zero-cycle latency). `EXE_MEM_bus` is combinational from the inputs and HI/LO.
- **`MULT` accepted at cycle T** (FSM in IDLE):
  - T+1 … T+32: RUN.
  - T+33: DONE, `EXE_over=1`.
  - Edge ending T+33: HI/LO updated.
  - Total latency 34 cycles including T.
- **Hazards.** No forwarding inside EXE. `mfhi`/`mflo` read the registered HI/LO, so a following MF instruction sees the new value.
- **Output reset values.**
  - `EXE_over` = `EXE_valid & ~multiply`.
  - `EXE_MEM_bus` follows the inputs; `exe_result` reflects HI/LO = 0.
  - `EXE_pc` = `pc`.

## Structure
- Shared package: the `alu_control` one-hot bit indices, the field offsets and widths of `ID_EXE_bus` (155) and `EXE_MEM_bus` (106), and the multiplier state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module `multiply`:
  - Inputs: `clk`, `reset`, `mult_begin`, `op1[31:0]`, `op2[31:0]`.
  - Outputs: `product[63:0]`, `mult_end`.
- The existing `alu` module is instantiated unchanged.

## Test plan
- **ADD:** add, op1=7, op2=5, EXE_valid=1 → `exe_result`=12 and `EXE_over`=1 in the same cycle; HI/LO unchanged.
- **Mixed-sign multiply:** MULT 3 × 0xFFFFFFFB (−5) → `EXE_over` low for T…T+32, high only at T+33; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **Extreme operands:** MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000 after 34 cycles.
- **MT/MF round trip:** mthi with op1=0x00001234, then mflo, then mfhi → `exe_result` = 0x00000000, then 0x00001234.
- **Reset mid-multiply:** MULT 100 × 200, `reset` at T+10 → FSM IDLE, no `EXE_over` pulse, HI=LO=0. A subsequent MULT 100 × 200 → LO=20000, HI=0 at the new T+33.
- **Invalid stage:** EXE_valid=0 with mthi, op1=0xDEAD → `EXE_over`=0, HI unchanged.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
// Holds the alu_control one-hot bit indices, the ID->EXE (155b) and
// EXE->MEM (106b) bus layouts, the multiplier state encoding and an
// absolute-value helper used by the multiplier.
package exe_pkg;

   localparam int unsigned ID_EXE_W  = 155;
   localparam int unsigned EXE_MEM_W = 106;
   localparam int unsigned ALU_CTL_W = 12;

   // alu_control one-hot bit positions (MSB = add)
   localparam int unsigned ALU_ADD  = 11;
   localparam int unsigned ALU_SUB  = 10;
   localparam int unsigned ALU_SLT  = 9;
   localparam int unsigned ALU_SLTU = 8;
   localparam int unsigned ALU_AND  = 7;
   localparam int unsigned ALU_NOR  = 6;
   localparam int unsigned ALU_OR   = 5;
   localparam int unsigned ALU_XOR  = 4;
   localparam int unsigned ALU_SLL  = 3;
   localparam int unsigned ALU_SRL  = 2;
   localparam int unsigned ALU_SRA  = 1;
   localparam int unsigned ALU_LUI  = 0;

   // ID_EXE_bus field LSB offsets
   localparam int unsigned IDB_PC_LSB     = 0;
   localparam int unsigned IDB_WDEST_LSB  = 32;
   localparam int unsigned IDB_WEN        = 37;
   localparam int unsigned IDB_STORE_LSB  = 38;
   localparam int unsigned IDB_MEMCTL_LSB = 70;
   localparam int unsigned IDB_OP2_LSB    = 74;
   localparam int unsigned IDB_OP1_LSB    = 106;
   localparam int unsigned IDB_ALUCTL_LSB = 138;
   localparam int unsigned IDB_MFLO       = 150;
   localparam int unsigned IDB_MFHI       = 151;
   localparam int unsigned IDB_MTLO       = 152;
   localparam int unsigned IDB_MTHI       = 153;
   localparam int unsigned IDB_MULT       = 154;

   // EXE_MEM_bus field LSB offsets
   localparam int unsigned EMB_PC_LSB     = 0;
   localparam int unsigned EMB_WDEST_LSB  = 32;
   localparam int unsigned EMB_WEN        = 37;
   localparam int unsigned EMB_RESULT_LSB = 38;
   localparam int unsigned EMB_STORE_LSB  = 70;
   localparam int unsigned EMB_MEMCTL_LSB = 102;

   typedef struct packed {
      logic        multiply;
      logic        mthi;
      logic        mtlo;
      logic        mfhi;
      logic        mflo;
      logic [11:0] alu_control;
      logic [31:0] alu_operand1;
      logic [31:0] alu_operand2;
      logic [3:0]  mem_control;
      logic [31:0] store_data;
      logic        rf_wen;
      logic [4:0]  rf_wdest;
      logic [31:0] pc;
   } id_exe_bus_t;

   typedef struct packed {
      logic [3:0]  mem_control;
      logic [31:0] store_data;
      logic [31:0] exe_result;
      logic        rf_wen;
      logic [4:0]  rf_wdest;
      logic [31:0] pc;
   } exe_mem_bus_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   // |v| as 32-bit unsigned; 0x80000000 maps to itself
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? 32'(-v) : v;
   endfunction

endpackage

// File: rtl/alu.sv
// alu: one-hot controlled combinational ALU.
// Ports: alu_control[11:0] one-hot op select, alu_src1/alu_src2 operands,
// alu_result[31:0]. Shifts move alu_src2 by alu_src1[4:0]; lui places
// alu_src2[15:0] in the upper half.
module alu
   import exe_pkg::*;
(
   input  logic [11:0] alu_control,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);

   logic [31:0] sum_c, diff_c, sra_c;
   logic        slt_c, sltu_c;

   assign sum_c  = alu_src1 + alu_src2;
   assign diff_c = alu_src1 - alu_src2;
   assign slt_c  = $signed(alu_src1) < $signed(alu_src2);
   assign sltu_c = alu_src1 < alu_src2;
   assign sra_c  = 32'($signed(alu_src2) >>> alu_src1[4:0]);

   // OR of the gated candidates; at most one control bit is set
   always_comb begin
      alu_result = '0;
      if (alu_control[ALU_ADD])  alu_result |= sum_c;
      if (alu_control[ALU_SUB])  alu_result |= diff_c;
      if (alu_control[ALU_SLT])  alu_result |= {31'd0, slt_c};
      if (alu_control[ALU_SLTU]) alu_result |= {31'd0, sltu_c};
      if (alu_control[ALU_AND])  alu_result |= alu_src1 & alu_src2;
      if (alu_control[ALU_NOR])  alu_result |= ~(alu_src1 | alu_src2);
      if (alu_control[ALU_OR])   alu_result |= alu_src1 | alu_src2;
      if (alu_control[ALU_XOR])  alu_result |= alu_src1 ^ alu_src2;
      if (alu_control[ALU_SLL])  alu_result |= alu_src2 << alu_src1[4:0];
      if (alu_control[ALU_SRL])  alu_result |= alu_src2 >> alu_src1[4:0];
      if (alu_control[ALU_SRA])  alu_result |= sra_c;
      if (alu_control[ALU_LUI])  alu_result |= {alu_src2[15:0], 16'd0};
   end

endmodule

// File: rtl/exe_multiply.sv
// multiply: iterative signed 32x32 -> 64 shift-and-add multiplier.
// Ports: clk, reset (sync, active-high), mult_begin (start when idle),
// op1/op2 signed operands, product[63:0] (valid while mult_end),
// mult_end (one-cycle pulse in DONE).
module multiply
   import exe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_begin,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic [63:0] product,
   output logic        mult_end
);

   mul_state_e  state_q;
   logic [63:0] acc_q;
   logic [63:0] mcand_q;
   logic [31:0] mplier_q;
   logic [5:0]  cnt_q;
   logic        sign_q;

   // Magnitudes are multiplied unsigned; sign is reapplied on the result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= MUL_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
      end else begin
         case (state_q)
            MUL_IDLE: begin
               if (mult_begin) begin
                  state_q  <= MUL_RUN;
                  mcand_q  <= {32'd0, abs32(op1)};
                  mplier_q <= abs32(op2);
                  sign_q   <= op1[31] ^ op2[31];
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            MUL_RUN: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_q <= MUL_DONE;
            end
            MUL_DONE: state_q <= MUL_IDLE;
            default:  state_q <= MUL_IDLE;
         endcase
      end
   end

   assign mult_end = (state_q == MUL_DONE);
   assign product  = sign_q ? 64'(-acc_q) : acc_q;

endmodule

// File: rtl/exe.sv
// exe: execute stage. Decodes the ID->EXE bus, runs the ALU, owns HI/LO,
// drives the iterative multiplier and builds the EXE->MEM bus.
// Ports: clk, reset (sync, active-high), EXE_valid, ID_EXE_bus_r[154:0],
// EXE_over (instruction done), EXE_MEM_bus[105:0], EXE_pc[31:0].
module exe
   import exe_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         EXE_valid,
   input  logic [154:0] ID_EXE_bus_r,
   output logic         EXE_over,
   output logic [105:0] EXE_MEM_bus,
   output logic [31:0]  EXE_pc
);

   id_exe_bus_t  id_c;
   exe_mem_bus_t mem_c;
   logic [31:0]  alu_result_c;
   logic [31:0]  exe_result_c;
   logic [63:0]  product_c;
   logic         mult_end_c;
   logic         mult_begin_c;
   logic [31:0]  hi_q, hi_d, lo_q, lo_d;

   assign id_c = id_exe_bus_t'(ID_EXE_bus_r);

   alu u_alu (
      .alu_control (id_c.alu_control),
      .alu_src1    (id_c.alu_operand1),
      .alu_src2    (id_c.alu_operand2),
      .alu_result  (alu_result_c)
   );

   assign mult_begin_c = EXE_valid & id_c.multiply;

   multiply u_multiply (
      .clk        (clk),
      .reset      (reset),
      .mult_begin (mult_begin_c),
      .op1        (id_c.alu_operand1),
      .op2        (id_c.alu_operand2),
      .product    (product_c),
      .mult_end   (mult_end_c)
   );

   // HI/LO next state; all writes gated by EXE_valid
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (EXE_valid & id_c.mthi) hi_d = id_c.alu_operand1;
      if (EXE_valid & id_c.mtlo) lo_d = id_c.alu_operand1;
      if (EXE_valid & id_c.multiply & mult_end_c) begin
         hi_d = product_c[63:32];
         lo_d = product_c[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign exe_result_c = id_c.mfhi ? hi_q :
                         id_c.mflo ? lo_q : alu_result_c;

   always_comb begin
      mem_c.mem_control = id_c.mem_control;
      mem_c.store_data  = id_c.store_data;
      mem_c.exe_result  = exe_result_c;
      mem_c.rf_wen      = id_c.rf_wen;
      mem_c.rf_wdest    = id_c.rf_wdest;
      mem_c.pc          = id_c.pc;
   end

   assign EXE_MEM_bus = mem_c;
   assign EXE_pc      = id_c.pc;
   assign EXE_over    = id_c.multiply ? mult_end_c : EXE_valid;

endmodule

// File: tb/tb_exe.sv
// tb_exe: scoreboard bench for the execute stage. Stimulus pushes the
// expected completion cycle and EXE_MEM_bus image; a negedge monitor
// checks EXE_over every cycle and compares bus/pc when an entry is due.
module tb_exe;

   logic         clk = 1'b0;
   logic         reset;
   logic         EXE_valid;
   logic [154:0] ID_EXE_bus_r;
   logic         EXE_over;
   logic [105:0] EXE_MEM_bus;
   logic [31:0]  EXE_pc;

   typedef struct {
      string        name;
      int           cyc;
      logic [105:0] bus;
      logic [31:0]  pc;
   } exp_t;

   exp_t        sb[$];
   exp_t        head;
   logic        exp_over;
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] pc_n   = 32'h0000_1000;

   localparam logic [4:0] F_MULT = 5'b10000;
   localparam logic [4:0] F_MTHI = 5'b01000;
   localparam logic [4:0] F_MTLO = 5'b00100;
   localparam logic [4:0] F_MFHI = 5'b00010;
   localparam logic [4:0] F_MFLO = 5'b00001;

   exe dut (
      .clk          (clk),
      .reset        (reset),
      .EXE_valid    (EXE_valid),
      .ID_EXE_bus_r (ID_EXE_bus_r),
      .EXE_over     (EXE_over),
      .EXE_MEM_bus  (EXE_MEM_bus),
      .EXE_pc       (EXE_pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Drive one instruction; optionally schedule its completion lat cycles on
   task automatic drive(input string nm, input logic v, input logic [4:0] fl,
                        input logic [11:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res,
                        input int lat, input logic push);
      logic [31:0] pc;
      pc   = pc_n;
      pc_n = pc_n + 32'd4;
      EXE_valid    = v;
      ID_EXE_bus_r = {fl, ctl, a, b, pc[3:0], ~pc, ~fl[4], pc[6:2], pc};
      if (push)
         sb.push_back('{name: nm, cyc: cyc + lat,
                        bus: {pc[3:0], ~pc, res, ~fl[4], pc[6:2], pc}, pc: pc});
   endtask

   task automatic op(input string nm, input logic [4:0] fl, input logic [11:0] ctl,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
      @(posedge clk); #1;
      drive(nm, 1'b1, fl, ctl, a, b, res, 0, 1'b1);
   endtask

   task automatic mult(input string nm, input logic [31:0] a, input logic [31:0] b);
      bit seen;
      seen = 0;
      @(posedge clk); #1;
      drive(nm, 1'b1, F_MULT, 12'h000, a, b, 32'd0, 33, 1'b1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (EXE_over === 1'b1) begin
            seen = 1;
            break;
         end
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_timeout: EXE_over not seen within 40 cycles", nm);
      end
   endtask

   // Monitor: EXE_over must be high exactly on scheduled cycles
   always @(negedge clk) begin
      if (cyc > 0) begin
         exp_over = (sb.size() > 0) && (sb[0].cyc == cyc);
         n_chk++;
         if (EXE_over !== exp_over) begin
            n_fail++;
            $display("FAIL over_timing cyc=%0d: got %b want %b", cyc, EXE_over, exp_over);
         end
         if (sb.size() > 0 && cyc >= sb[0].cyc) begin
            head = sb.pop_front();
            n_chk++;
            if (EXE_MEM_bus !== head.bus) begin
               n_fail++;
               $display("FAIL %s_bus: got %h want %h (result got %h want %h)", head.name,
                        EXE_MEM_bus, head.bus, EXE_MEM_bus[69:38], head.bus[69:38]);
            end
            n_chk++;
            if (EXE_pc !== head.pc) begin
               n_fail++;
               $display("FAIL %s_pc: got %h want %h", head.name, EXE_pc, head.pc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      EXE_valid    = 1'b0;
      ID_EXE_bus_r = '0;
      @(posedge clk); #1;
      // Reset state: HI reads back zero while reset is still asserted
      drive("rst_mfhi", 1'b1, F_MFHI, 12'h000, 32'd0, 32'd0, 32'd0, 0, 1'b1);
      @(posedge clk); #1;
      reset     = 1'b0;
      EXE_valid = 1'b0;
      op("rst_mflo", F_MFLO, 12'h000, 32'd0, 32'd0, 32'd0);

      // ALU operations
      op("add",  5'b0, 12'h800, 32'd7,          32'd5,          32'd12);
      op("sub",  5'b0, 12'h400, 32'd5,          32'd7,          32'hFFFF_FFFE);
      op("slt",  5'b0, 12'h200, 32'hFFFF_FFFF,  32'd1,          32'd1);
      op("sltu", 5'b0, 12'h100, 32'hFFFF_FFFF,  32'd1,          32'd0);
      op("and",  5'b0, 12'h080, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000);
      op("nor",  5'b0, 12'h040, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h000F_000F);
      op("or",   5'b0, 12'h020, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0);
      op("xor",  5'b0, 12'h010, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0);
      op("sll",  5'b0, 12'h008, 32'd4,          32'd1,          32'h0000_0010);
      op("srl",  5'b0, 12'h004, 32'd4,          32'h8000_0000,  32'h0800_0000);
      op("sra",  5'b0, 12'h002, 32'd4,          32'h8000_0000,  32'hF800_0000);
      op("lui",  5'b0, 12'h001, 32'd0,          32'h0000_1234,  32'h1234_0000);
      op("add_hi", F_MFHI, 12'h000, 32'd0, 32'd0, 32'd0);

      // Mixed-sign multiply, then back-to-back restart with two negatives
      mult("mul_3xm5", 32'd3, 32'hFFFF_FFFB);
      op("m1_hi", F_MFHI, 12'h000, 32'd0, 32'd0, 32'hFFFF_FFFF);
      op("m1_lo", F_MFLO, 12'h000, 32'd0, 32'd0, 32'hFFFF_FFF1);
      mult("mul_3xm5b", 32'd3, 32'hFFFF_FFFB);
      mult("mul_m7xm6", 32'hFFFF_FFF9, 32'hFFFF_FFFA);
      op("m2_lo", F_MFLO, 12'h000, 32'd0, 32'd0, 32'd42);
      op("m2_hi", F_MFHI, 12'h000, 32'd0, 32'd0, 32'd0);

      // Extreme operands
      mult("mul_min", 32'h8000_0000, 32'h8000_0000);
      op("m3_hi", F_MFHI, 12'h000, 32'd0, 32'd0, 32'h4000_0000);
      op("m3_lo", F_MFLO, 12'h000, 32'd0, 32'd0, 32'h0000_0000);

      // MT/MF round trip
      op("mthi",   F_MTHI, 12'h000, 32'h0000_1234, 32'd0, 32'd0);
      op("rt_lo",  F_MFLO, 12'h000, 32'd0, 32'd0, 32'h0000_0000);
      op("rt_hi",  F_MFHI, 12'h000, 32'd0, 32'd0, 32'h0000_1234);

      // Invalid stage: write must be blocked and EXE_over stays low
      @(posedge clk); #1;
      drive("mthi_inv", 1'b0, F_MTHI, 12'h000, 32'h0000_DEAD, 32'd0, 32'd0, 0, 1'b0);
      op("inv_hi", F_MFHI, 12'h000, 32'd0, 32'd0, 32'h0000_1234);
      op("mtlo",   F_MTLO, 12'h000, 32'h0000_0055, 32'd0, 32'd0);
      op("mt_lo",  F_MFLO, 12'h000, 32'd0, 32'd0, 32'h0000_0055);

      // Reset in the middle of a multiply: no pulse, HI/LO cleared
      @(posedge clk); #1;
      drive("mul_abort", 1'b1, F_MULT, 12'h000, 32'd100, 32'd200, 32'd0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset     = 1'b1;
      EXE_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      op("ab_hi", F_MFHI, 12'h000, 32'd0, 32'd0, 32'd0);
      op("ab_lo", F_MFLO, 12'h000, 32'd0, 32'd0, 32'd0);
      mult("mul_100x200", 32'd100, 32'd200);
      op("m4_lo", F_MFLO, 12'h000, 32'd0, 32'd0, 32'd20000);
      op("m4_hi", F_MFHI, 12'h000, 32'd0, 32'd0, 32'd0);

      @(posedge clk); #1;
      EXE_valid    = 1'b0;
      ID_EXE_bus_r = '0;
      repeat (3) @(posedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
